// File: rtl/nv_ram_arb_pkg.sv
// Shared constants and types for the nv_ram_rws_512x64 read/write arbiter.
package nv_ram_arb_pkg;
   localparam int unsigned RAM_AW = 9;
   localparam int unsigned RAM_DW = 64;

   localparam logic CLI_RD0 = 1'b0;
   localparam logic CLI_RD1 = 1'b1;

   typedef struct packed {
      logic              vld;
      logic              owner;
      logic [RAM_AW-1:0] addr;
   } rsp_slot_t;
endpackage

// File: rtl/nv_ram_arb_rr2.sv
// Two-way read grant: round-robin or fixed priority (req[0] wins), one-hot output.
module nv_ram_arb_rr2
   import nv_ram_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (RR_EN && (last_grant == CLI_RD0)) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Reset to rd1 so that rd0 takes the first contested grant.
   always_ff @(posedge clk) begin
      if (!rstn)
         last_grant <= CLI_RD1;
      else if (|gnt)
         last_grant <= gnt[1];
   end

endmodule

// File: rtl/nv_ram_rws_512x64_arb.sv
// Shares one 512x64 RAM between two read clients and one write client, one read in flight.
module nv_ram_rws_512x64_arb
   import nv_ram_arb_pkg::*;
#(
   parameter bit          RR_EN       = 1'b1,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rstn,
   input  logic                   rd0_req_vld,
   output logic                   rd0_req_rdy,
   input  logic [RAM_AW-1:0]      rd0_req_addr,
   output logic                   rd0_rsp_vld,
   input  logic                   rd0_rsp_rdy,
   output logic [RAM_DW-1:0]      rd0_rsp_data,
   input  logic                   rd1_req_vld,
   output logic                   rd1_req_rdy,
   input  logic [RAM_AW-1:0]      rd1_req_addr,
   output logic                   rd1_rsp_vld,
   input  logic                   rd1_rsp_rdy,
   output logic [RAM_DW-1:0]      rd1_rsp_data,
   input  logic                   wr_req_vld,
   output logic                   wr_req_rdy,
   input  logic [RAM_AW-1:0]      wr_req_addr,
   input  logic [RAM_DW-1:0]      wr_req_data,
   output logic                   ram_re,
   output logic [RAM_AW-1:0]      ram_ra,
   input  logic [RAM_DW-1:0]      ram_dout,
   output logic                   ram_we,
   output logic [RAM_AW-1:0]      ram_wa,
   output logic [RAM_DW-1:0]      ram_di,
   output logic [STALL_CNT_W-1:0] wr_stall_cnt
);

   rsp_slot_t  slot;
   logic       rsp_fire;
   logic       slot_free;
   logic       hazard;
   logic [1:0] gnt;

   assign rsp_fire  = slot.vld & ((slot.owner == CLI_RD1) ? rd1_rsp_rdy : rd0_rsp_rdy);
   assign slot_free = ~slot.vld | rsp_fire;

   nv_ram_arb_rr2 #(.RR_EN(RR_EN)) u_rr2 (
      .clk  (nvdla_core_clk),
      .rstn (nvdla_core_rstn),
      .en   (slot_free & nvdla_core_rstn),
      .req  ({rd1_req_vld, rd0_req_vld}),
      .gnt  (gnt)
   );

   assign rd0_req_rdy = gnt[0];
   assign rd1_req_rdy = gnt[1];
   assign ram_re      = |gnt;
   assign ram_ra      = gnt[1] ? rd1_req_addr : rd0_req_addr;

   // The RAM keeps dout stable while re is low, so responses come straight off it.
   assign rd0_rsp_vld  = nvdla_core_rstn & slot.vld & (slot.owner == CLI_RD0);
   assign rd1_rsp_vld  = nvdla_core_rstn & slot.vld & (slot.owner == CLI_RD1);
   assign rd0_rsp_data = ram_dout;
   assign rd1_rsp_data = ram_dout;

   // A write to the held address would change dout under an unaccepted response.
   assign hazard     = slot.vld & ~rsp_fire & (wr_req_addr == slot.addr);
   assign wr_req_rdy = nvdla_core_rstn & ~hazard;
   assign ram_we     = nvdla_core_rstn & wr_req_vld & ~hazard;
   assign ram_wa     = wr_req_addr;
   assign ram_di     = wr_req_data;

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         slot <= '0;
      end else if (ram_re) begin
         slot.vld   <= 1'b1;
         slot.owner <= gnt[1];
         slot.addr  <= ram_ra;
      end else if (rsp_fire) begin
         slot.vld <= 1'b0;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn)
         wr_stall_cnt <= '0;
      else if (wr_req_vld && hazard && (wr_stall_cnt != '1))
         wr_stall_cnt <= wr_stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_nv_ram_rws_512x64_arb.sv
// Bench for nv_ram_rws_512x64_arb: round-robin and fixed-priority instances, each on its own RAM model.
module tb_nv_ram_rws_512x64_arb;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, rv0, rv1, rr0, rr1, wv;
   logic [8:0]  ra0, ra1, wa;
   logic [63:0] wd;

   logic          rd0_req_rdy [2], rd1_req_rdy [2], rd0_rsp_vld [2], rd1_rsp_vld [2];
   logic          wr_req_rdy [2], ram_re [2], ram_we [2];
   logic [63:0]   rd0_rsp_data [2], rd1_rsp_data [2], ram_dout [2], ram_di [2];
   logic [8:0]    ram_ra [2], ram_wa [2];
   logic [CW-1:0] stall_cnt [2];

   // Instance 0 is round-robin, instance 1 fixed priority; both see the same stimulus.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [63:0] mem [512] = '{default: '0};
      logic [8:0]  ra_q = '0;
      always @(posedge clk) begin
         if (ram_re[g]) ra_q <= ram_ra[g];
         if (ram_we[g]) mem[ram_wa[g]] <= ram_di[g];
      end
      assign ram_dout[g] = mem[ra_q];

      nv_ram_rws_512x64_arb #(.RR_EN(g == 0), .STALL_CNT_W(CW)) u_dut (
         .nvdla_core_clk  (clk),
         .nvdla_core_rstn (rstn),
         .rd0_req_vld     (rv0),
         .rd0_req_rdy     (rd0_req_rdy[g]),
         .rd0_req_addr    (ra0),
         .rd0_rsp_vld     (rd0_rsp_vld[g]),
         .rd0_rsp_rdy     (rr0),
         .rd0_rsp_data    (rd0_rsp_data[g]),
         .rd1_req_vld     (rv1),
         .rd1_req_rdy     (rd1_req_rdy[g]),
         .rd1_req_addr    (ra1),
         .rd1_rsp_vld     (rd1_rsp_vld[g]),
         .rd1_rsp_rdy     (rr1),
         .rd1_rsp_data    (rd1_rsp_data[g]),
         .wr_req_vld      (wv),
         .wr_req_rdy      (wr_req_rdy[g]),
         .wr_req_addr     (wa),
         .wr_req_data     (wd),
         .ram_re          (ram_re[g]),
         .ram_ra          (ram_ra[g]),
         .ram_dout        (ram_dout[g]),
         .ram_we          (ram_we[g]),
         .ram_wa          (ram_wa[g]),
         .ram_di          (ram_di[g]),
         .wr_stall_cnt    (stall_cnt[g])
      );
   end

   // Reference model: memory image plus the single outstanding-read slot.
   logic [63:0] m_mem [2][512];
   bit          m_pend [2], m_own [2], m_last [2];
   logic [8:0]  m_addr [2];
   int          m_cnt [2];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input int m, input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, m, obs, exp);
      end
   endtask

   task automatic step();
      bit grant [2], gid [2], fire [2], wen [2], blk [2];
      #1;
      for (int m = 0; m < 2; m++) begin
         bit free, haz;
         fire[m]  = m_pend[m] && (m_own[m] ? rr1 : rr0);
         free     = !m_pend[m] || fire[m];
         grant[m] = rstn && free && (rv0 || rv1);
         gid[m]   = (rv0 && rv1) ? ((m == 0) ? !m_last[m] : 1'b0) : rv1;
         haz      = m_pend[m] && !fire[m] && (wa == m_addr[m]);
         wen[m]   = rstn && wv && !haz;
         blk[m]   = wv && haz;
         chk(m, "rd0_req_rdy", 64'(rd0_req_rdy[m]), 64'(grant[m] && !gid[m]));
         chk(m, "rd1_req_rdy", 64'(rd1_req_rdy[m]), 64'(grant[m] && gid[m]));
         chk(m, "ram_re", 64'(ram_re[m]), 64'(grant[m]));
         if (grant[m]) chk(m, "ram_ra", 64'(ram_ra[m]), 64'(gid[m] ? ra1 : ra0));
         chk(m, "rd0_rsp_vld", 64'(rd0_rsp_vld[m]), 64'(rstn && m_pend[m] && !m_own[m]));
         chk(m, "rd1_rsp_vld", 64'(rd1_rsp_vld[m]), 64'(rstn && m_pend[m] && m_own[m]));
         if (rstn && m_pend[m]) begin
            chk(m, "rd0_rsp_data", rd0_rsp_data[m], m_mem[m][m_addr[m]]);
            chk(m, "rd1_rsp_data", rd1_rsp_data[m], m_mem[m][m_addr[m]]);
         end
         chk(m, "wr_req_rdy", 64'(wr_req_rdy[m]), 64'(rstn && !haz));
         chk(m, "ram_we", 64'(ram_we[m]), 64'(wen[m]));
         if (wen[m]) begin
            chk(m, "ram_wa", 64'(ram_wa[m]), 64'(wa));
            chk(m, "ram_di", ram_di[m], wd);
         end
         chk(m, "wr_stall_cnt", 64'(stall_cnt[m]), 64'(m_cnt[m]));
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (!rstn) begin
            m_pend[m] = 1'b0; m_own[m] = 1'b0; m_addr[m] = '0; m_last[m] = 1'b1; m_cnt[m] = 0;
         end else begin
            if (wen[m]) m_mem[m][wa] = wd;
            if (grant[m]) begin
               m_pend[m] = 1'b1; m_own[m] = gid[m]; m_addr[m] = gid[m] ? ra1 : ra0; m_last[m] = gid[m];
            end else if (fire[m]) begin
               m_pend[m] = 1'b0;
            end
            if (blk[m] && m_cnt[m] < CMAX) m_cnt[m]++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 512; i++) m_mem[m][i] = '0;
         m_pend[m] = 1'b0; m_own[m] = 1'b0; m_addr[m] = '0; m_last[m] = 1'b1; m_cnt[m] = 0;
      end
      rstn = 1'b0; rv0 = 1'b0; rv1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0; wv = 1'b0;
      ra0 = '0; ra1 = '0; wa = '0; wd = '0;
      @(negedge clk);

      // Reset: everything held low even with requests present.
      rv0 = 1'b1; rv1 = 1'b1; wv = 1'b1;
      #1;
      chk(0, "rst_rd0_req_rdy", 64'(rd0_req_rdy[0]), 64'd0);
      chk(0, "rst_ram_re", 64'(ram_re[0]), 64'd0);
      chk(0, "rst_ram_we", 64'(ram_we[0]), 64'd0);
      chk(0, "rst_wr_req_rdy", 64'(wr_req_rdy[0]), 64'd0);
      step(); step();
      rv0 = 1'b0; rv1 = 1'b0; wv = 1'b0;
      rstn = 1'b1;

      // Write then read back through rd0, response one cycle after grant.
      wv = 1'b1; wa = 9'd5; wd = 64'hA5A5_0000_0000_0005;
      step();
      wv = 1'b0; rv0 = 1'b1; ra0 = 9'd5;
      #1 chk(0, "t1_grant", 64'(rd0_req_rdy[0]), 64'd1);
      step();
      rv0 = 1'b0; rr0 = 1'b1;
      #1;
      chk(0, "t1_rsp_vld", 64'(rd0_rsp_vld[0]), 64'd1);
      chk(0, "t1_rsp_data", rd0_rsp_data[0], 64'hA5A5_0000_0000_0005);
      step();

      // Contention: alternate under round-robin (rd0 won last), rd0 always under fixed priority.
      rv0 = 1'b1; rv1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ra0 = 9'($urandom_range(16, 63)); ra1 = 9'($urandom_range(16, 63));
         #1;
         chk(0, "rr_rd0", 64'(rd0_req_rdy[0]), 64'(i % 2 == 1));
         chk(0, "rr_rd1", 64'(rd1_req_rdy[0]), 64'(i % 2 == 0));
         chk(1, "fp_rd0", 64'(rd0_req_rdy[1]), 64'd1);
         chk(1, "fp_rd1", 64'(rd1_req_rdy[1]), 64'd0);
         step();
      end

      // Backpressure: rd1 holds its response, rd0 is locked out until it drains.
      rv0 = 1'b0; rv1 = 1'b1; ra1 = 9'd7; rr1 = 1'b0;
      step();
      rv1 = 1'b0; rv0 = 1'b1; ra0 = 9'd3;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk(0, "bp_rsp_vld", 64'(rd1_rsp_vld[0]), 64'd1);
         chk(0, "bp_rd0_blocked", 64'(rd0_req_rdy[0]), 64'd0);
         chk(0, "bp_data", rd1_rsp_data[0], m_mem[0][7]);
         step();
      end
      rr1 = 1'b1;
      #1 chk(0, "bp_release", 64'(rd0_req_rdy[0]), 64'd1);
      step();
      rv0 = 1'b0;
      step();

      // Write hazard against held response at 7; an unrelated address passes.
      rv1 = 1'b1; ra1 = 9'd7; rr1 = 1'b0;
      step();
      rv1 = 1'b0; wv = 1'b1; wa = 9'd7; wd = {$urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk(0, "hz_wr_rdy", 64'(wr_req_rdy[0]), 64'd0);
         chk(0, "hz_cnt", 64'(stall_cnt[0]), 64'(k));
         step();
      end
      wa = 9'd8;
      #1;
      chk(0, "hz_other_rdy", 64'(wr_req_rdy[0]), 64'd1);
      chk(0, "hz_other_we", 64'(ram_we[0]), 64'd1);
      chk(0, "hz_cnt_hold", 64'(stall_cnt[0]), 64'd3);
      step();
      wa = 9'd7; rr1 = 1'b1;
      #1 chk(0, "hz_fire_rdy", 64'(wr_req_rdy[0]), 64'd1);
      step();

      // Same-cycle read and write to 9 returns the new data.
      rv0 = 1'b1; ra0 = 9'd9; rr0 = 1'b1; wa = 9'd9; wd = 64'h1234;
      step();
      rv0 = 1'b0; wv = 1'b0;
      #1;
      chk(0, "wf_vld", 64'(rd0_rsp_vld[0]), 64'd1);
      chk(0, "wf_data", rd0_rsp_data[0], 64'h1234);
      step();

      // Reset while a response is pending drops it.
      rv0 = 1'b1; ra0 = 9'd11; rr0 = 1'b0;
      step();
      rv0 = 1'b0; rstn = 1'b0;
      #1 chk(0, "mr_vld_in_rst", 64'(rd0_rsp_vld[0]), 64'd0);
      step();
      rstn = 1'b1;
      #1 chk(0, "mr_vld_after", 64'(rd0_rsp_vld[0]), 64'd0);
      step(); step();

      // Random traffic on a narrow address window to provoke hazards and saturation.
      for (int i = 0; i < 600; i++) begin
         rstn = ($urandom_range(0, 59) != 0);
         rv0  = 1'($urandom_range(0, 1));
         rv1  = 1'($urandom_range(0, 1));
         rr0  = ($urandom_range(0, 3) != 0);
         rr1  = ($urandom_range(0, 3) != 0);
         wv   = 1'($urandom_range(0, 1));
         ra0  = 9'($urandom_range(0, 7));
         ra1  = 9'($urandom_range(0, 7));
         wa   = 9'($urandom_range(0, 7));
         wd   = {$urandom, $urandom};
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
